// File: rtl/pc_next_seq.sv
// pc_next_seq: next-PC sequencer with return-address stack and sticky fault flag.
// Ports: clk, rst, en, op, cond, target, pc_cur -> addr_next, sp, stk_empty, stk_full, err.
// Build option: define SEQ_TRAP_EN to redirect stack faults to TRAP_VEC.
module pc_next_seq #(
  parameter int            AW        = 8,
  parameter int            DEPTH     = 4,
  parameter logic [AW-1:0] RESET_VEC = '0,
  parameter logic [AW-1:0] TRAP_VEC  = AW'(8'hF0),
  localparam int           SPW       = $clog2(DEPTH) + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [2:0]     op,
  input  logic           cond,
  input  logic [AW-1:0]  target,
  input  logic [AW-1:0]  pc_cur,
  output logic [AW-1:0]  addr_next,
  output logic [SPW-1:0] sp,
  output logic           stk_empty,
  output logic           stk_full,
  output logic           err
);

  localparam int IW = $clog2(DEPTH);

`ifdef SEQ_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic [AW-1:0] stk [DEPTH];

  logic [AW-1:0]  inc;
  logic [AW-1:0]  fault_addr;
  logic [AW-1:0]  nxt_addr;
  logic [SPW-1:0] nxt_sp;
  logic           nxt_err;
  logic           push;
  logic [IW-1:0]  wr_idx;
  logic [IW-1:0]  rd_idx;

  logic is_hold, is_inc, is_jmp, is_brc, is_call, is_ret;

  assign inc        = pc_cur + AW'(1);
  assign fault_addr = TRAP_EN ? TRAP_VEC : inc;

  assign stk_empty = (sp == '0);
  assign stk_full  = (sp == SPW'(DEPTH));

  assign wr_idx = IW'(sp);
  assign rd_idx = IW'(sp - SPW'(1));

  assign is_hold = (op == 3'd0);
  assign is_inc  = (op == 3'd1);
  assign is_jmp  = (op == 3'd2);
  assign is_brc  = (op == 3'd3);
  assign is_call = (op == 3'd4);
  assign is_ret  = (op == 3'd5);

  always_comb begin
    nxt_addr = inc;
    nxt_sp   = sp;
    nxt_err  = err;
    push     = 1'b0;
    unique case (1'b1)
      is_hold: nxt_addr = pc_cur;
      is_inc:  nxt_addr = inc;
      is_jmp:  nxt_addr = target;
      is_brc:  nxt_addr = cond ? target : inc;
      is_call: begin
        if (stk_full) begin
          nxt_err  = 1'b1;
          nxt_addr = fault_addr;
        end else begin
          push     = 1'b1;
          nxt_sp   = sp + SPW'(1);
          nxt_addr = target;
        end
      end
      is_ret: begin
        if (stk_empty) begin
          nxt_err  = 1'b1;
          nxt_addr = fault_addr;
        end else begin
          nxt_sp   = sp - SPW'(1);
          nxt_addr = stk[rd_idx];
        end
      end
      // reserved encodings advance like INC
      default: nxt_addr = inc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_next <= RESET_VEC;
      sp        <= '0;
      err       <= 1'b0;
    end else if (en) begin
      addr_next <= nxt_addr;
      sp        <= nxt_sp;
      err       <= nxt_err;
    end
  end

  // stack storage needs no reset; sp alone defines valid entries
  always_ff @(posedge clk) begin
    if (!rst && en && push) begin
      stk[wr_idx] <= inc;
    end
  end

endmodule

// File: tb/tb_pc_next_seq.sv
// tb_pc_next_seq: scoreboard bench for pc_next_seq.
// Directed plan sequences followed by random ops against a queue-based model.
module tb_pc_next_seq;

  localparam int AW    = 8;
  localparam int DEPTH = 4;

  localparam logic [2:0] HOLD = 3'd0;
  localparam logic [2:0] INC  = 3'd1;
  localparam logic [2:0] JMP  = 3'd2;
  localparam logic [2:0] BRC  = 3'd3;
  localparam logic [2:0] CALL = 3'd4;
  localparam logic [2:0] RET  = 3'd5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [2:0]    op = 3'd0;
  logic          cond = 1'b0;
  logic [AW-1:0] target = '0;
  logic [AW-1:0] pc_cur = '0;
  logic [AW-1:0] addr_next;
  logic [2:0]    sp;
  logic          stk_empty;
  logic          stk_full;
  logic          err;

  always #5 clk = ~clk;

  pc_next_seq #(
    .AW(AW),
    .DEPTH(DEPTH),
    .RESET_VEC(8'h00),
    .TRAP_VEC(8'hF0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .op(op),
    .cond(cond),
    .target(target),
    .pc_cur(pc_cur),
    .addr_next(addr_next),
    .sp(sp),
    .stk_empty(stk_empty),
    .stk_full(stk_full),
    .err(err)
  );

  typedef struct packed {
    logic [7:0] addr;
    logic [2:0] sp;
    logic       empty;
    logic       full;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  logic [7:0] m_addr = 8'h00;
  logic       m_err = 1'b0;
  logic [7:0] m_stk[$];

  task automatic step(input logic r, input logic e, input logic [2:0] o,
                      input logic c, input logic [7:0] t, input logic [7:0] p);
    logic [7:0] nx;
    logic [7:0] flt;
    exp_t       x;
    @(negedge clk);
    rst = r; en = e; op = o; cond = c; target = t; pc_cur = p;
    @(posedge clk);
    #1;
    nx = p + 8'd1;
`ifdef SEQ_TRAP_EN
    flt = 8'hF0;
`else
    flt = nx;
`endif
    if (r) begin
      m_addr = 8'h00;
      m_err  = 1'b0;
      m_stk.delete();
    end else if (e) begin
      case (o)
        HOLD: m_addr = p;
        JMP:  m_addr = t;
        BRC:  m_addr = c ? t : nx;
        CALL: begin
          if (m_stk.size() == DEPTH) begin
            m_err  = 1'b1;
            m_addr = flt;
          end else begin
            m_stk.push_back(nx);
            m_addr = t;
          end
        end
        RET: begin
          if (m_stk.size() == 0) begin
            m_err  = 1'b1;
            m_addr = flt;
          end else begin
            m_addr = m_stk.pop_back();
          end
        end
        default: m_addr = nx;
      endcase
    end
    x.addr  = m_addr;
    x.sp    = 3'(m_stk.size());
    x.empty = (m_stk.size() == 0);
    x.full  = (m_stk.size() == DEPTH);
    x.err   = m_err;
    sb.push_back(x);
  endtask

  initial begin : monitor
    exp_t e;
    exp_t a;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        a = {addr_next, sp, stk_empty, stk_full, err};
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL vec%0d: got addr=%h sp=%0d empty=%b full=%b err=%b, want addr=%h sp=%0d empty=%b full=%b err=%b",
                   vectors, a.addr, a.sp, a.empty, a.full, a.err,
                   e.addr, e.sp, e.empty, e.full, e.err);
        end
      end
    end
  end

  initial begin : driver
    // reset then increment, including wrap
    step(1, 1, INC, 0, 8'h00, 8'h01);
    step(0, 1, INC, 0, 8'h00, 8'h01);
    step(0, 1, INC, 0, 8'h00, 8'hFF);
    // jump and branch
    step(0, 1, JMP, 0, 8'hF0, 8'h02);
    step(0, 1, BRC, 0, 8'h33, 8'h0F);
    step(0, 1, BRC, 1, 8'h07, 8'h10);
    step(0, 1, HOLD, 0, 8'h99, 8'h44);
    // nested call/return
    step(0, 1, CALL, 0, 8'h40, 8'h0A);
    step(0, 1, CALL, 0, 8'h50, 8'h0C);
    step(0, 1, RET, 0, 8'h00, 8'h51);
    step(0, 1, RET, 0, 8'h00, 8'h0E);
    // overflow
    step(1, 1, INC, 0, 8'h00, 8'h00);
    for (int i = 0; i < 5; i++)
      step(0, 1, CALL, 0, 8'h60, 8'(8'h20 + i));
    for (int i = 0; i < 4; i++)
      step(0, 1, RET, 0, 8'h00, 8'h70);
    // underflow, then hold with en low
    step(1, 1, INC, 0, 8'h00, 8'h00);
    step(0, 1, RET, 0, 8'h00, 8'h30);
    step(0, 0, JMP, 0, 8'hAA, 8'h31);
    step(0, 0, CALL, 0, 8'hAB, 8'h32);
    // reset mid-operation
    step(0, 1, CALL, 0, 8'h80, 8'h33);
    step(0, 1, CALL, 0, 8'h90, 8'h81);
    step(1, 1, CALL, 0, 8'hA0, 8'h91);
    step(0, 1, RET, 0, 8'h00, 8'h55);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [2:0] o;
      o = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1)
        o = 3'($urandom_range(4, 5));
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0), o,
           1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
    end
    for (int i = 0; i < 10 && sb.size() > 0; i++)
      @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
